state_estimator_mac: RTL
========================

STATE_ESTIMATOR_MAC -- requirements
Module: state_estimator_mac

Interface
REQ-001 Parameter WIDTH, default 16, signed two's-complement data width of all matrix, vector and state elements.
REQ-002 Parameter FRAC, default 8, fractional bits of the fixed-point format (Q(WIDTH-FRAC).FRAC); 0 <= FRAC < WIDTH.
REQ-003 Parameters nos, noo, noi, defaults 4, 2, 2: number of states, outputs and inputs; each >= 1.
REQ-004 clk  in  1  sole clock; all registers update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 clk_en  in  1  when low, every register holds its value.
REQ-007 start  in  1  requests one operation; sampled only in IDLE with clk_en high.
REQ-008 mode  in  2  01 predict, 10 update, 11 predict then update, 00 illegal.
REQ-009 load_x0  in  1  loads X_0 into both state vectors; honoured only in IDLE.
REQ-010 A[nos][nos], B[nos][noi], C[noo][nos], K[nos][noo]  in  WIDTH each  model and gain matrices; held stable by the user while busy.
REQ-011 U[noi], Y[noo], X_0[nos]  in  WIDTH each  plant input, plant output and initial state.
REQ-012 busy  out  1  high from the cycle after start acceptance until done is asserted.
REQ-013 done  out  1  one-cycle registered pulse marking completion.
REQ-014 err  out  1  one-cycle pulse for a rejected start.
REQ-015 sat_flag  out  1  sticky; set on any saturation during the current operation.
REQ-016 x_pred[nos], x_upd[nos]  out  WIDTH each  X(nk|nk-1) and X(nk|nk).

Function
REQ-017 Arithmetic: one signed WIDTHxWIDTH multiply-accumulate per enabled cycle; accumulator width >= 2*WIDTH+clog2(nos+noi+1), no internal wrap.
REQ-018 Writeback: accumulator arithmetic-shifted right by FRAC (floor), then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; any clipping sets sat_flag.
REQ-019 FSM states: IDLE, PRED, INNOV, CORR, DONE; IDLE->PRED (mode 01/11) or IDLE->INNOV (mode 10) on accepted start.
REQ-020 PRED: per row i, accumulate A[i][j]*x_upd[j] for j=0..nos-1, then B[i][k]*U[k] for k=0..noi-1, write x_pred[i]; exactly nos*(nos+noi) cycles, then INNOV for mode 11 or DONE for mode 01.
REQ-021 INNOV: per row r, accumulator preset to Y[r]<<FRAC, subtract C[r][j]*x_pred[j]; saturated result stored in internal e[r]; nos*noo cycles, then CORR.
REQ-022 CORR: per row i, accumulator preset to x_pred[i]<<FRAC, add K[i][r]*e[r]; write x_upd[i]; nos*noo cycles, then DONE.
REQ-023 DONE: done=1 for one cycle, busy=0, next state IDLE; a start in the DONE cycle is rejected (err).
REQ-024 Latency, counted in enabled cycles from the start-accept edge to the edge raising done: mode 01 nos*(nos+noi)+1, mode 10 2*nos*noo+1, mode 11 nos*(nos+noi)+2*nos*noo+1 (defaults: 25, 17, 41).
REQ-025 U and Y are captured into internal registers at start acceptance; later changes do not affect the running operation.
REQ-026 sat_flag is cleared at start acceptance and holds its value after done until the next accepted start.
REQ-027 start with mode 00, or start when not in IDLE: no state change, err=1 next cycle, running operation unaffected.
REQ-028 load_x0 and start both high in IDLE: X_0 is loaded first and the operation uses X_0 as its initial state; load_x0 outside IDLE is ignored.
REQ-029 With clk_en low, the FSM, counters, accumulator, outputs and pulses freeze; latency stretches by the number of disabled cycles.

Reset
REQ-030 When reset is asserted, regardless of clk: state=IDLE, counters=0, accumulator=0, x_pred=x_upd=0, e=0, busy=done=err=sat_flag=0.
REQ-031 Reset during an operation aborts it with no done pulse; the first start after reset release is accepted normally.

Verification
REQ-032 WIDTH=16, FRAC=8, A=256*I, B=0, X_0={256,512,-256,0}, load_x0, then start mode 01 -> done on enabled cycle 25, x_pred={256,512,-256,0}, sat_flag=0.
REQ-033 Then C rows {256,0,0,0} and {0,256,0,0}, Y={512,512}, K[0][0]=K[1][1]=128 (others 0), start mode 10 -> e={256,0}, x_upd={384,512,-256,0}, done on cycle 17.
REQ-034 A[0][0]=32767, x_upd[0]=32767, mode 01 -> x_pred[0]=32767 and sat_flag=1; the next start clears sat_flag.
REQ-035 Mode 11 with start re-pulsed at cycle 5 and mode 00 start while idle -> err pulse each time, done still on cycle 41.
REQ-036 Reset asserted at cycle 10 of mode 11 -> all outputs 0 immediately, no done; clk_en held low for 7 cycles mid-run -> done on cycle 48.

Source files
------------

// File: rtl/state_estimator_mac.sv
// Fixed-point state estimator: predict x = A*x + B*u, then correct x = x + K*(y - C*x),
// using one shared signed multiply-accumulate per enabled cycle.
module state_estimator_mac #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int nos   = 4,
  parameter int noo   = 2,
  parameter int noi   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_en,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic                    load_x0,
  input  logic signed [WIDTH-1:0] A   [nos][nos],
  input  logic signed [WIDTH-1:0] B   [nos][noi],
  input  logic signed [WIDTH-1:0] C   [noo][nos],
  input  logic signed [WIDTH-1:0] K   [nos][noo],
  input  logic signed [WIDTH-1:0] U   [noi],
  input  logic signed [WIDTH-1:0] Y   [noo],
  input  logic signed [WIDTH-1:0] X_0 [nos],
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    sat_flag,
  output logic signed [WIDTH-1:0] x_pred [nos],
  output logic signed [WIDTH-1:0] x_upd  [nos]
);

  localparam int ACC_W = 2*WIDTH + $clog2(nos+noi+1) + 1;
  localparam int MAXD  = (nos+noi > noo) ? nos+noi : noo;
  localparam int CNT_W = $clog2(MAXD+1);

  typedef enum logic [2:0] {S_IDLE, S_PRED, S_INNOV, S_CORR, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          row_q, row_d, col_q, col_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [1:0]                mode_q, mode_d;
  logic signed [WIDTH-1:0]   u_q [noi], u_d [noi];
  logic signed [WIDTH-1:0]   y_q [noo], y_d [noo];
  logic signed [WIDTH-1:0]   e_q [noo], e_d [noo];
  logic signed [WIDTH-1:0]   x_pred_q [nos], x_pred_d [nos];
  logic signed [WIDTH-1:0]   x_upd_q  [nos], x_upd_d  [nos];
  logic                      busy_q, busy_d, done_q, done_d, err_q, err_d, sat_q, sat_d;

  logic signed [WIDTH-1:0]   op_a, op_b, wb;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   preset, base, sum, shifted;
  logic                      sub, last_col, last_row, clip;

  // Operand routing and writeback arithmetic for the current MAC step.
  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    op_a     = '0;
    op_b     = '0;
    preset   = '0;
    sub      = 1'b0;
    last_col = 1'b0;
    last_row = 1'b0;
    unique case (state_q)
      S_PRED: begin
        last_col = (col_q == CNT_W'(nos+noi-1));
        last_row = (row_q == CNT_W'(nos-1));
        for (int i = 0; i < nos; i++) begin
          if (row_q == CNT_W'(i)) begin
            for (int j = 0; j < nos; j++)
              if (col_q == CNT_W'(j)) begin op_a = A[i][j]; op_b = x_upd_q[j]; end
            for (int k = 0; k < noi; k++)
              if (col_q == CNT_W'(nos+k)) begin op_a = B[i][k]; op_b = u_q[k]; end
          end
        end
      end
      S_INNOV: begin
        sub      = 1'b1;
        last_col = (col_q == CNT_W'(nos-1));
        last_row = (row_q == CNT_W'(noo-1));
        for (int r = 0; r < noo; r++) begin
          if (row_q == CNT_W'(r)) begin
            preset = ACC_W'(y_q[r]) <<< FRAC;
            for (int j = 0; j < nos; j++)
              if (col_q == CNT_W'(j)) begin op_a = C[r][j]; op_b = x_pred_q[j]; end
          end
        end
      end
      S_CORR: begin
        last_col = (col_q == CNT_W'(noo-1));
        last_row = (row_q == CNT_W'(nos-1));
        for (int i = 0; i < nos; i++) begin
          if (row_q == CNT_W'(i)) begin
            preset = ACC_W'(x_pred_q[i]) <<< FRAC;
            for (int r = 0; r < noo; r++)
              if (col_q == CNT_W'(r)) begin op_a = K[i][r]; op_b = e_q[r]; end
          end
        end
      end
      default: ;
    endcase

    prod    = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);
    base    = (col_q == '0) ? preset : acc_q;
    sum     = sub ? base - ACC_W'(prod) : base + ACC_W'(prod);
    shifted = sum >>> FRAC;
    clip    = !((&shifted[ACC_W-1:WIDTH-1]) || !(|shifted[ACC_W-1:WIDTH-1]));
    if (!clip)                wb = shifted[WIDTH-1:0];
    else if (shifted[ACC_W-1]) wb = {1'b1, {(WIDTH-1){1'b0}}};
    else                      wb = {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    acc_d    = acc_q;
    mode_d   = mode_q;
    u_d      = u_q;
    y_d      = y_q;
    e_d      = e_q;
    x_pred_d = x_pred_q;
    x_upd_d  = x_upd_q;
    busy_d   = busy_q;
    sat_d    = sat_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_x0) begin
          x_pred_d = X_0;
          x_upd_d  = X_0;
        end
        if (start) begin
          if (mode == 2'b00) begin
            err_d = 1'b1;
          end else begin
            mode_d  = mode;
            u_d     = U;
            y_d     = Y;
            sat_d   = 1'b0;
            busy_d  = 1'b1;
            row_d   = '0;
            col_d   = '0;
            acc_d   = '0;
            state_d = (mode == 2'b10) ? S_INNOV : S_PRED;
          end
        end
      end
      S_PRED, S_INNOV, S_CORR: begin
        err_d = start;
        acc_d = sum;
        if (last_col) begin
          col_d = '0;
          if (clip) sat_d = 1'b1;
          for (int i = 0; i < nos; i++) begin
            if (row_q == CNT_W'(i)) begin
              if (state_q == S_PRED) x_pred_d[i] = wb;
              if (state_q == S_CORR) x_upd_d[i]  = wb;
            end
          end
          for (int r = 0; r < noo; r++)
            if (state_q == S_INNOV && row_q == CNT_W'(r)) e_d[r] = wb;
          if (last_row) begin
            row_d = '0;
            unique case (state_q)
              S_PRED:  state_d = (mode_q == 2'b11) ? S_INNOV : S_DONE;
              S_INNOV: state_d = S_CORR;
              default: state_d = S_DONE;
            endcase
          end else begin
            row_d = row_q + CNT_W'(1);
          end
        end else begin
          col_d = col_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        err_d   = start;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the small state/error arrays are reset explicitly; their zero value is visible at the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      acc_q    <= '0;
      mode_q   <= '0;
      u_q      <= '{default: '0};
      y_q      <= '{default: '0};
      e_q      <= '{default: '0};
      x_pred_q <= '{default: '0};
      x_upd_q  <= '{default: '0};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      u_q      <= u_d;
      y_q      <= y_d;
      e_q      <= e_d;
      x_pred_q <= x_pred_d;
      x_upd_q  <= x_upd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      sat_q    <= sat_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign sat_flag = sat_q;
  assign x_pred   = x_pred_q;
  assign x_upd    = x_upd_q;

endmodule
